dequantize_stream: RTL and testbench

- Streaming JPEG dequantizer: inverse of the 64-coefficient quantizer stage.
- Accepts Q16.16 quantized coefficients one per beat in raster order (index 0..63 per 8x8 block).
- Multiplies each coefficient by the matching standard JPEG luma or chroma table entry and emits Q16.16 results to the IDCT stage.
- Valid/ready handshake on both sides, 2-stage pipeline.

---
 rtl/dequantize_stream.sv | 146 ++++++++++++++
 tb/tb_dequantize_stream.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dequantize_stream.sv
// Streaming JPEG dequantizer: Q16.16 coefficient times the Annex K luma/chroma table entry, 2-stage pipeline.
// Optional macro DEQUANT_ROUND_INPUT_EN rounds in_data to the nearest integer (half away from zero) first.
module dequantize_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int PIXEL_COUNT = 64,
  parameter int FRAC_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel_chroma,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [5:0]            out_idx,
  output logic                  out_last,
  output logic                  out_sat
);

  localparam int EXT_W  = DATA_WIDTH + 1;
  localparam int PROD_W = EXT_W + 9;
  localparam logic [5:0] LAST_IDX = 6'(PIXEL_COUNT - 1);
  localparam logic signed [PROD_W-1:0] SAT_MAX = (PROD_W'(1) <<< (DATA_WIDTH - 1)) - PROD_W'(1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = -SAT_MAX - PROD_W'(1);

`ifdef DEQUANT_ROUND_INPUT_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  // With rounding off, half=0 and mask=all-ones make the rounding path an identity.
  localparam logic signed [EXT_W-1:0] RND_HALF =
    ROUND_EN ? (EXT_W'(1) <<< (FRAC_BITS - 1)) : '0;
  localparam logic signed [EXT_W-1:0] RND_MASK =
    ROUND_EN ? ~((EXT_W'(1) <<< FRAC_BITS) - EXT_W'(1)) : '1;

  localparam logic [7:0] LUMA_Q [64] = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24, 8'd40, 8'd51, 8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26, 8'd58, 8'd60, 8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40, 8'd57, 8'd69, 8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51, 8'd87, 8'd80, 8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68, 8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81, 8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  // Chroma table: everything outside the upper-left corner is 99.
  function automatic logic [7:0] chroma_q(input logic [5:0] i);
    case (i)
      6'd0:    chroma_q = 8'd17;
      6'd1:    chroma_q = 8'd18;
      6'd2:    chroma_q = 8'd24;
      6'd3:    chroma_q = 8'd47;
      6'd8:    chroma_q = 8'd18;
      6'd9:    chroma_q = 8'd21;
      6'd10:   chroma_q = 8'd26;
      6'd11:   chroma_q = 8'd66;
      6'd16:   chroma_q = 8'd24;
      6'd17:   chroma_q = 8'd26;
      6'd18:   chroma_q = 8'd56;
      6'd24:   chroma_q = 8'd47;
      6'd25:   chroma_q = 8'd66;
      default: chroma_q = 8'd99;
    endcase
  endfunction

  logic [5:0]              idx;
  logic                    sel_lat;
  logic                    s1_valid;
  logic signed [EXT_W-1:0] s1_data;
  logic [5:0]              s1_idx;
  logic [7:0]              s1_q;

  logic                    advance;
  logic                    accept;
  logic                    use_chroma;
  logic [7:0]              q_now;
  logic signed [EXT_W-1:0] x_ext, x_mag, x_rnd, x_adj;
  logic signed [PROD_W-1:0] prod;
  logic [DATA_WIDTH-1:0]   sat_data;
  logic                    sat;

  // Handshake: a beat moves on a side when valid && ready in the same cycle; the source holds data while ready is low.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  always_comb begin
    use_chroma = (idx == 6'd0) ? sel_chroma : sel_lat;
    q_now      = use_chroma ? chroma_q(idx) : LUMA_Q[idx];
    x_ext      = {in_data[DATA_WIDTH-1], in_data};
    x_mag      = x_ext[EXT_W-1] ? -x_ext : x_ext;
    x_rnd      = (x_mag + RND_HALF) & RND_MASK;
    x_adj      = x_ext[EXT_W-1] ? -x_rnd : x_rnd;
  end

  always_comb begin
    prod     = PROD_W'(s1_data) * PROD_W'($signed({1'b0, s1_q}));
    sat_data = prod[DATA_WIDTH-1:0];
    sat      = 1'b0;
    if (prod > SAT_MAX) begin
      sat_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      sat      = 1'b1;
    end else if (prod < SAT_MIN) begin
      sat_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      sat      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      sel_lat   <= 1'b0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_idx    <= '0;
      s1_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (advance) begin
      s1_valid  <= accept;
      out_valid <= s1_valid;
      if (accept) begin
        s1_data <= x_adj;
        s1_idx  <= idx;
        s1_q    <= q_now;
        idx     <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
        if (idx == 6'd0) sel_lat <= sel_chroma;
      end
      if (s1_valid) begin
        out_data <= sat_data;
        out_idx  <= s1_idx;
        out_last <= (s1_idx == LAST_IDX);
        out_sat  <= sat;
      end
    end
  end

endmodule

// File: tb/tb_dequantize_stream.sv
// Randomized bench for dequantize_stream: arithmetic reference model feeding an expected queue, plus directed checks.
module tb_dequantize_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel_chroma = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
  logic        out_last;
  logic        out_sat;

  always #5 clk = ~clk;

  dequantize_stream dut (
    .clk(clk), .rst_n(rst_n), .sel_chroma(sel_chroma),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .out_sat(out_sat)
  );

  int luma_t [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99
  };
  int chroma_t [64] = '{
    17, 18, 24, 47, 99, 99, 99, 99,   18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,   47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99
  };

  int          total = 0;
  int          bad = 0;
  logic [39:0] exp_q [$];
  logic [39:0] exp_e;
  int          m_idx = 0;
  bit          m_sel = 1'b0;
  int          acc_cnt = 0;
  bit          rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: round (optional), multiply by the table entry, clamp to 32-bit signed.
  function automatic logic [39:0] model_beat(input logic [31:0] d, input bit chroma, input int idx);
    longint x, p;
    logic [31:0] r;
    bit s;
    int q;
    x = longint'($signed(d));
`ifdef DEQUANT_ROUND_INPUT_EN
    if (x >= 0) x = ((x + 32768) / 65536) * 65536;
    else        x = -((((-x) + 32768) / 65536) * 65536);
`endif
    q = chroma ? chroma_t[idx] : luma_t[idx];
    p = x * q;
    s = 1'b1;
    if (p > 64'sd2147483647)       r = 32'h7FFF_FFFF;
    else if (p < -64'sd2147483648) r = 32'h8000_0000;
    else begin
      r = p[31:0];
      s = 1'b0;
    end
    return {s, (idx == 63), 6'(idx), r};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_idx = 0;
      m_sel = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("out_data", out_data, exp_e[31:0]);
          check("out_idx", out_idx, exp_e[37:32]);
          check("out_last", out_last, exp_e[38]);
          check("out_sat", out_sat, exp_e[39]);
        end
      end
      if (in_valid && in_ready) begin
        if (m_idx == 0) m_sel = sel_chroma;
        exp_q.push_back(model_beat(in_data, m_sel, m_idx));
        m_idx = (m_idx + 1) % 64;
        acc_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [31:0] rnd_data();
    logic [31:0] r;
    r = $urandom;
    return $signed(r) >>> $urandom_range(0, 20);
  endfunction

  // Holds the beat until it is accepted; returns 1 ns after the accepting edge with in_valid still high.
  task automatic send_beat(input logic [31:0] d, input bit sel);
    bit ok;
    ok = 1'b0;
    in_valid   = 1'b1;
    in_data    = d;
    sel_chroma = sel;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", ok, 1'b1);
  endtask

  task automatic send_rand(input int n, input int sel_mode);
    for (int i = 0; i < n; i++)
      send_beat(rnd_data(), (sel_mode == 2) ? 1'($urandom_range(0, 1)) : sel_mode[0]);
  endtask

  task automatic drain();
    int w;
    w = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  logic [31:0] hold_data;
  logic [5:0]  hold_idx;
  int          base;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_idx", out_idx, 6'd0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_sat", out_sat, 1'b0);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1'b1);

    // Luma block with a latency probe on the first beat.
    send_beat(32'h0001_0000, 1'b0);
    in_valid = 1'b0;
    check("lat_cycle1", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_cycle2", out_valid, 1'b1);
    check("dir_idx0_data", out_data, 32'h0010_0000);
    check("dir_idx0_idx", out_idx, 6'd0);
    check("dir_idx0_sat", out_sat, 1'b0);
    send_beat(32'hFFFF_0000, 1'b0);
    send_rand(61, 2);
    send_beat(32'h0001_0000, 1'b1);

    // Chroma block with sel_chroma toggled mid-block.
    send_beat(32'h0002_0000, 1'b1);
    send_rand(4, 1);
    send_beat(32'h0001_0000, 1'b0);
    send_rand(58, 2);

    // Saturation in both directions.
    send_beat(32'h7FFF_0000, 1'b0);
    send_beat(32'h8000_0000, 1'b0);
    send_rand(62, 2);

    // Half-integer input, random backpressure.
    rand_ready = 1'b1;
    send_beat(32'h0001_8000, 1'b0);
    send_rand(63, 2);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();

    // Back-to-back block with a 5-cycle stall after 10 accepts.
    base = acc_cnt;
    fork
      begin
        send_rand(64, 2);
        in_valid = 1'b0;
      end
      begin
        int w;
        w = 0;
        while (acc_cnt < base + 10 && w < 500) begin
          @(posedge clk);
          #1;
          w++;
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (i == 0) begin
            hold_data = out_data;
            hold_idx  = out_idx;
          end
          check("stall_valid", out_valid, 1'b1);
          check("stall_in_ready", in_ready, 1'b0);
          check("stall_data", out_data, hold_data);
          check("stall_idx", out_idx, hold_idx);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a block.
    send_rand(20, 2);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    send_beat(rnd_data(), 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_next_idx", out_idx, 6'd0);
    send_rand(63, 2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
